image_pixel_proc: RTL and testbench
===================================

IMAGE_PIXEL_PROC -- requirements
Module: image_pixel_proc

Interface
REQ-001 SHALL have parameter WIDTH, default 768, meaning pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 512, meaning lines per frame.
REQ-003 SHALL have parameter MODE, default 1, meaning operation: 0 brightness, 1 grayscale, 2 threshold.
REQ-004 SHALL have parameter VALUE, default 100, meaning brightness offset (8-bit).
REQ-005 SHALL have parameter SIGN, default 1, meaning brightness direction: 1 add, 0 subtract.
REQ-006 SHALL have parameter THRESHOLD, default 90, meaning threshold-mode cut level (8-bit).
REQ-007 SHALL have HCLK  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have HRESET  input  1  synchronous, active-high reset.
REQ-009 SHALL have HSYNC_IN  input  1  pixel-valid strobe from image_read.
REQ-010 SHALL have DATA_R_IN, DATA_G_IN, DATA_B_IN  input  8 each  input pixel.
REQ-011 SHALL have HSYNC_OUT  output  1  pixel-valid strobe to image_write.
REQ-012 SHALL have DATA_R_OUT, DATA_G_OUT, DATA_B_OUT  output  8 each  processed pixel.
REQ-013 SHALL have LINE_END  output  1  high with last valid pixel of each line.
REQ-014 SHALL have FRAME_DONE  output  1  one-cycle pulse after last pixel of frame.

Function
REQ-015 SHALL implement a 3-stage, non-stalling pipeline: S1 register inputs + valid; S2 arithmetic; S3 saturate/select and drive outputs.
REQ-016 SHALL produce HSYNC_OUT and data exactly 3 HCLK cycles after the corresponding HSYNC_IN cycle.
REQ-017 SHALL accept arbitrary gaps in HSYNC_IN; each stage valid bit propagates independently every cycle.
REQ-018 SHALL hold DATA_*_OUT at last value while HSYNC_OUT low.
REQ-019 Brightness, SIGN=1: each channel out = min(in + VALUE, 255), computed in 9 bits.
REQ-020 Brightness, SIGN=0: each channel out = max(in - VALUE, 0), 9-bit signed check of borrow.
REQ-021 Grayscale: g = (77*R + 150*G + 29*B) >> 8; 16-bit sum (max 65280, no overflow); R=G=B out = g[7:0].
REQ-022 Threshold: g computed as REQ-021; all channels out = 255 if g > THRESHOLD else 0 (g == THRESHOLD -> 0).
REQ-023 SHALL keep column counter (0..WIDTH-1) and row counter (0..HEIGHT-1) advanced only on output-valid cycles.
REQ-024 Column wraps WIDTH-1 -> 0 with row increment; LINE_END = HSYNC_OUT & (col == WIDTH-1).
REQ-025 At col == WIDTH-1 and row == HEIGHT-1 with HSYNC_OUT, both counters SHALL wrap to 0 and FRAME_DONE SHALL pulse high for exactly the next cycle.
REQ-026 Input pixels beyond one frame SHALL be processed as the next frame without stall or loss.
REQ-027 Unsupported MODE values SHALL pass pixels through unmodified with 3-cycle latency.

Reset
REQ-028 When HRESET high at a clock edge, all stage valids, HSYNC_OUT, LINE_END, FRAME_DONE, DATA_*_OUT, and counters SHALL be 0 next cycle.
REQ-029 Reset mid-frame SHALL discard in-flight pixels (no HSYNC_OUT for them) and restart counting at row 0, col 0.
REQ-030 HSYNC_IN asserted during reset SHALL be ignored; first pixel after reset deassertion appears 3 cycles later.

Verification
REQ-031 MODE=1, single pixel R=100,G=50,B=200 -> 3 cycles later HSYNC_OUT=1, all channels 82; R=G=B=255 -> 255.
REQ-032 MODE=0, SIGN=1, VALUE=100, pixel (200,50,155) -> (255,150,255); SIGN=0, pixel (60,100,255) -> (0,0,155).
REQ-033 MODE=2, THRESHOLD=90, pixels with g=82, 90, 91 -> outputs 0, 0, 255.
REQ-034 WIDTH=4, HEIGHT=2, 8 contiguous valid pixels then 5 more with gaps -> LINE_END on output pixels 4 and 8, FRAME_DONE one cycle after pixel 8, next frame's LINE_END on pixel 12.
REQ-035 Assert HRESET for 1 cycle while 3 pixels in flight -> none emerge, all outputs 0, next frame counts from col 0.
REQ-036 Full 768x512 frame streamed into image_write -> exactly 393216 HSYNC_OUT cycles, one FRAME_DONE pulse, output image matches software model bit-exact.

Source files
------------

// File: rtl/image_pixel_proc.sv
// image_pixel_proc: three-stage, non-stalling pixel pipeline between image_read and image_write.
//
// Stage 1 registers the incoming pixel and its valid strobe, stage 2 does the arithmetic
// (brightness add/sub or the weighted grayscale sum), and stage 3 saturates/selects the result
// and drives the outputs. Output pixels appear exactly 3 HCLK cycles after their HSYNC_IN cycle.
// Every stage valid bit moves forward each cycle, so gaps in HSYNC_IN simply travel down the pipe.
//
// Parameters:
//   WIDTH     pixels per line
//   HEIGHT    lines per frame
//   MODE      0 brightness, 1 grayscale, 2 threshold, other values pass pixels through
//   VALUE     brightness offset (8-bit)
//   SIGN      brightness direction: 1 add, 0 subtract
//   THRESHOLD threshold-mode cut level (8-bit)
//
// Ports:
//   HCLK                              clock, all logic on the rising edge
//   HRESET                            synchronous active-high reset
//   HSYNC_IN                          input pixel valid
//   DATA_R_IN, DATA_G_IN, DATA_B_IN   input pixel
//   HSYNC_OUT                         output pixel valid
//   DATA_R_OUT, DATA_G_OUT, DATA_B_OUT processed pixel, held while HSYNC_OUT is low
//   LINE_END                          high with the last valid pixel of each line
//   FRAME_DONE                        one-cycle pulse in the cycle after the last pixel of a frame

module image_pixel_proc #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int MODE      = 1,
    parameter int VALUE     = 100,
    parameter int SIGN      = 1,
    parameter int THRESHOLD = 90
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSYNC_IN,
    input  logic [7:0] DATA_R_IN,
    input  logic [7:0] DATA_G_IN,
    input  logic [7:0] DATA_B_IN,
    output logic       HSYNC_OUT,
    output logic [7:0] DATA_R_OUT,
    output logic [7:0] DATA_G_OUT,
    output logic [7:0] DATA_B_OUT,
    output logic       LINE_END,
    output logic       FRAME_DONE
);

    localparam logic [7:0] Val8 = 8'(VALUE);
    localparam logic [7:0] Thr8 = 8'(THRESHOLD);
    localparam int ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);

    // ---------------- Stage 1: input register ----------------
    logic       s1_valid_q;
    logic [7:0] s1_r_q, s1_g_q, s1_b_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= 8'd0;
            s1_g_q     <= 8'd0;
            s1_b_q     <= 8'd0;
        end else begin
            s1_valid_q <= HSYNC_IN;
            if (HSYNC_IN) begin
                s1_r_q <= DATA_R_IN;
                s1_g_q <= DATA_G_IN;
                s1_b_q <= DATA_B_IN;
            end
        end
    end

    // ---------------- Stage 2: arithmetic ----------------
    // Channel results are kept 9 bits wide: bit 8 is the carry (add) or borrow (subtract)
    // that stage 3 uses to saturate. Outside brightness mode they carry the raw pixel.
    logic       s2_valid_q;
    logic [8:0] s2_r_q, s2_g_q, s2_b_q;
    logic [8:0] s2_r_d, s2_g_d, s2_b_d;
    logic [7:0] s2_gray_q, s2_gray_d;
    logic [15:0] gray_sum;

    function automatic logic [8:0] bright_arith(input logic [7:0] x);
        if (SIGN != 0) begin
            return {1'b0, x} + {1'b0, Val8};
        end else begin
            return {1'b0, x} - {1'b0, Val8};
        end
    endfunction

    always_comb begin
        // Weights sum to 256, so the maximum is 255 * 256 = 65280 and 16 bits never overflow.
        gray_sum  = 16'd77 * {8'd0, s1_r_q} + 16'd150 * {8'd0, s1_g_q}
                  + 16'd29 * {8'd0, s1_b_q};
        s2_gray_d = 8'(gray_sum >> 8);
        if (MODE == 0) begin
            s2_r_d = bright_arith(s1_r_q);
            s2_g_d = bright_arith(s1_g_q);
            s2_b_d = bright_arith(s1_b_q);
        end else begin
            s2_r_d = {1'b0, s1_r_q};
            s2_g_d = {1'b0, s1_g_q};
            s2_b_d = {1'b0, s1_b_q};
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            s2_valid_q <= 1'b0;
            s2_r_q     <= 9'd0;
            s2_g_q     <= 9'd0;
            s2_b_q     <= 9'd0;
            s2_gray_q  <= 8'd0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_r_q    <= s2_r_d;
                s2_g_q    <= s2_g_d;
                s2_b_q    <= s2_b_d;
                s2_gray_q <= s2_gray_d;
            end
        end
    end

    // ---------------- Stage 3: saturate / select ----------------
    logic [7:0] out_r_d, out_g_d, out_b_d;

    function automatic logic [7:0] bright_sat(input logic [8:0] v);
        if (SIGN != 0) begin
            return v[8] ? 8'hFF : v[7:0];
        end else begin
            return v[8] ? 8'h00 : v[7:0];
        end
    endfunction

    always_comb begin
        case (MODE)
            0: begin
                out_r_d = bright_sat(s2_r_q);
                out_g_d = bright_sat(s2_g_q);
                out_b_d = bright_sat(s2_b_q);
            end
            1: begin
                out_r_d = s2_gray_q;
                out_g_d = s2_gray_q;
                out_b_d = s2_gray_q;
            end
            2: begin
                // Equal to the cut level maps to black.
                out_r_d = (s2_gray_q > Thr8) ? 8'hFF : 8'h00;
                out_g_d = out_r_d;
                out_b_d = out_r_d;
            end
            default: begin
                out_r_d = s2_r_q[7:0];
                out_g_d = s2_g_q[7:0];
                out_b_d = s2_b_q[7:0];
            end
        endcase
    end

    logic       hsync_q;
    logic [7:0] out_r_q, out_g_q, out_b_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hsync_q <= 1'b0;
            out_r_q <= 8'd0;
            out_g_q <= 8'd0;
            out_b_q <= 8'd0;
        end else begin
            hsync_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_r_q <= out_r_d;
                out_g_q <= out_g_d;
                out_b_q <= out_b_d;
            end
        end
    end

    // ---------------- Output position counters ----------------
    // col/row index the pixel currently on the outputs; they step only on output-valid cycles.
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            frame_done_q, frame_done_d;
    logic            at_col_last, at_row_last;

    always_comb begin
        at_col_last  = (col_q == ColLast);
        at_row_last  = (row_q == RowLast);
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (hsync_q) begin
            if (at_col_last) begin
                col_d = '0;
                if (at_row_last) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign HSYNC_OUT  = hsync_q;
    assign DATA_R_OUT = out_r_q;
    assign DATA_G_OUT = out_g_q;
    assign DATA_B_OUT = out_b_q;
    assign LINE_END   = hsync_q & at_col_last;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_image_pixel_proc.sv
// Bench for image_pixel_proc: five instances (grayscale, brightness add, brightness subtract,
// threshold, pass-through) share one stimulus stream on a 4x2 frame. Expected pixels are pushed
// to a scoreboard queue when driven and popped when the outputs should show them.

module tb_image_pixel_proc;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = 5;

    function automatic int p_mode(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 0;
            3:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int p_sign(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    logic       clk;
    logic       HRESET;
    logic       HSYNC_IN;
    logic [7:0] r_in, g_in, b_in;
    logic       hs_o [N];
    logic [7:0] ro [N];
    logic [7:0] go [N];
    logic [7:0] bo [N];
    logic       le_o [N];
    logic       fd_o [N];

    for (genvar i = 0; i < N; i++) begin : g_dut
        image_pixel_proc #(
            .WIDTH    (W),
            .HEIGHT   (H),
            .MODE     (p_mode(i)),
            .VALUE    (100),
            .SIGN     (p_sign(i)),
            .THRESHOLD(90)
        ) u_dut (
            .HCLK      (clk),
            .HRESET    (HRESET),
            .HSYNC_IN  (HSYNC_IN),
            .DATA_R_IN (r_in),
            .DATA_G_IN (g_in),
            .DATA_B_IN (b_in),
            .HSYNC_OUT (hs_o[i]),
            .DATA_R_OUT(ro[i]),
            .DATA_G_OUT(go[i]),
            .DATA_B_OUT(bo[i]),
            .LINE_END  (le_o[i]),
            .FRAME_DONE(fd_o[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                   cyc;
        logic [N-1:0][23:0]   px;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   errs = 0;

    // Reference model, written from the arithmetic definitions with plain integers.
    function automatic int bright(input int i, input int v);
        if (p_sign(i) == 1) return (v + 100 > 255) ? 255 : v + 100;
        else                return (v < 100) ? 0 : v - 100;
    endfunction

    function automatic logic [23:0] model(input int i, input int r, input int g, input int b);
        int gy;
        int o_r, o_g, o_b;
        gy = (77 * r + 150 * g + 29 * b) / 256;
        case (p_mode(i))
            0: begin
                o_r = bright(i, r); o_g = bright(i, g); o_b = bright(i, b);
            end
            1: begin
                o_r = gy; o_g = gy; o_b = gy;
            end
            2: begin
                o_r = (gy > 90) ? 255 : 0; o_g = o_r; o_b = o_r;
            end
            default: begin
                o_r = r; o_g = g; o_b = b;
            end
        endcase
        return {8'(o_r), 8'(o_g), 8'(o_b)};
    endfunction

    task automatic check(input string tag, input int i, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, got, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic [23:0] last [N];
    bit          fd_exp = 1'b0;
    int          mcol = 0;
    int          mrow = 0;

    initial begin
        bit   ev;
        bit   le;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (HRESET) begin
                for (int i = 0; i < N; i++) begin
                    check("rst_hsync", i, 32'(hs_o[i]), 32'd0);
                    check("rst_line_end", i, 32'(le_o[i]), 32'd0);
                    check("rst_frame_done", i, 32'(fd_o[i]), 32'd0);
                    check("rst_data", i, 32'({ro[i], go[i], bo[i]}), 32'd0);
                    last[i] = 24'd0;
                end
                mcol   = 0;
                mrow   = 0;
                fd_exp = 1'b0;
            end else begin
                ev = (q.size() > 0) && (q[0].cyc + 3 == cyc);
                le = ev && (mcol == W - 1);
                if (ev) e = q[0];
                for (int i = 0; i < N; i++) begin
                    check("hsync", i, 32'(hs_o[i]), 32'(ev));
                    check("line_end", i, 32'(le_o[i]), 32'(le));
                    check("frame_done", i, 32'(fd_o[i]), 32'(fd_exp));
                    if (ev) begin
                        check("data", i, 32'({ro[i], go[i], bo[i]}), 32'(e.px[i]));
                        last[i] = e.px[i];
                    end else begin
                        check("data_hold", i, 32'({ro[i], go[i], bo[i]}), 32'(last[i]));
                    end
                end
                if (ev) begin
                    void'(q.pop_front());
                    fd_exp = (mcol == W - 1) && (mrow == H - 1);
                    if (mcol == W - 1) begin
                        mcol = 0;
                        mrow = (mrow == H - 1) ? 0 : mrow + 1;
                    end else begin
                        mcol++;
                    end
                end else begin
                    fd_exp = 1'b0;
                end
            end
        end
    end

    // One input cycle, driven on the falling edge.
    task automatic drive(input bit rst, input bit v, input int r, input int g, input int b);
        exp_t e;
        @(negedge clk);
        HRESET   = rst;
        HSYNC_IN = v;
        r_in     = 8'(r);
        g_in     = 8'(g);
        b_in     = 8'(b);
        if (rst) q.delete();
        if (v && !rst) begin
            e.cyc = cyc;
            for (int i = 0; i < N; i++) e.px[i] = model(i, r, g, b);
            q.push_back(e);
        end
    endtask

    task automatic send(input int r, input int g, input int b);
        drive(1'b0, 1'b1, r, g, b);
    endtask

    // Idle cycles with garbage on the data lines.
    task automatic gap(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    endtask

    initial begin
        HRESET   = 1'b1;
        HSYNC_IN = 1'b0;
        r_in     = 8'd0;
        g_in     = 8'd0;
        b_in     = 8'd0;

        // Reset with valid pixels presented: they must be ignored.
        drive(1'b1, 1'b1, 11, 22, 33);
        drive(1'b1, 1'b1, 44, 55, 66);

        // Single pixel, then idle so it is observed alone (gray 82).
        send(100, 50, 200);
        gap(4);

        // Rest of frame 1 contiguously: white, brightness cases, gray 90 and 91.
        send(255, 255, 255);
        send(200, 50, 155);
        send(60, 100, 255);
        send(90, 90, 90);
        send(91, 91, 91);
        send(0, 0, 0);
        send(10, 20, 30);

        // Frame 2 start: five pixels with gaps.
        send(1, 2, 3);
        gap(1);
        send(250, 5, 99);
        send(100, 100, 100);
        gap(2);
        send(101, 99, 255);
        gap(3);
        send(30, 200, 120);

        // Random contiguous pixels, wrapping into frame 3.
        for (int k = 0; k < 6; k++)
            send($urandom_range(255), $urandom_range(255), $urandom_range(255));
        gap(4);

        // Mid-frame reset with three pixels in flight.
        send(200, 200, 200);
        send(150, 150, 150);
        drive(1'b1, 1'b1, 120, 120, 120);
        gap(1);

        // Fresh frame: counting restarts at column 0.
        send(7, 8, 9);
        send(17, 18, 19);
        gap(1);
        send(27, 28, 29);
        send(37, 38, 39);
        for (int k = 0; k < 4; k++)
            send($urandom_range(255), $urandom_range(255), $urandom_range(255));

        // Bounded drain: every pushed pixel must have emerged.
        gap(8);
        check("drain_queue_empty", 0, 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
